// File: rtl/timer.sv
// -----------------------------------------------------------------------------
// timer -- completion timer for the self-timed ripple adder.
//
// The adder pulses F at the start of each addition and exposes the propagate
// bits around its middle slices (P[17:14]) on middle_p. At the F edge this
// block classifies the longest run of consecutive propagate bits, latches a
// wait of class*QUARTER cycles, counts it down, and then raises R. R gates
// the adder output buffer, so it is always driven straight from a flop.
//
// Parameters:
//   QUARTER  clock cycles per quarter of worst-case carry-chain delay (>= 1)
//   CNT_W    width of the cycle counter (must hold 4*QUARTER)
//
// Ports:
//   clk       in   1  rising-edge clock (adder clock domain)
//   rst_n     in   1  asynchronous active-low reset
//   middle_p  in   4  propagate bits P[17:14]; bit 3 = P[17]
//   F         in   1  start strobe; each high edge restarts timing
//   R         out  1  result ready; high once the sum is settled
//
// State table:
//   state | meaning
//   IDLE  | no addition timed since reset, R=0
//   COUNT | counter running towards the latched wait, R=0
//   DONE  | wait elapsed, R=1 held until the next F or reset
// -----------------------------------------------------------------------------
module timer #(
    parameter int unsigned QUARTER = 1,
    parameter int unsigned CNT_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] middle_p,
    input  logic       F,
    output logic       R
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] QTR     = CNT_W'(QUARTER);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       class_q, class_d;
    logic             r_q, r_d;

    logic [2:0]       class_c;
    logic             adjacent_c;
    logic [CNT_W-1:0] wait_len;
    logic             wait_hit;

    // Run classification of the live propagate bits. Only the value present
    // at the F edge is kept; later changes of middle_p are ignored.
    assign adjacent_c = (middle_p[3] & middle_p[2]) |
                        (middle_p[2] & middle_p[1]) |
                        (middle_p[1] & middle_p[0]);

    always_comb begin
        class_c = 3'd1;
        if (middle_p == 4'b1111) begin
            class_c = 3'd4;
        end else if ((middle_p == 4'b0111) || (middle_p == 4'b1110)) begin
            class_c = 3'd3;
        end else if (adjacent_c) begin
            class_c = 3'd2;
        end
    end

    // Wait length derived from the latched class, not the live input.
    assign wait_len = CNT_W'(class_q) * QTR;

    // The counter starts at 1 on the F edge, so comparing the pre-increment
    // value against the wait puts the rise of R exactly W edges after F.
    assign wait_hit = (cnt_q == wait_len);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            class_q <= '0;
            r_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            class_q <= class_d;
            r_q     <= r_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        class_d = class_q;

        if (F) begin
            // F restarts from any state, abandoning whatever was in flight.
            state_d = COUNT;
            cnt_d   = CNT_ONE;
            class_d = class_c;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                COUNT: begin
                    if (wait_hit) begin
                        state_d = DONE;
                    end else if (cnt_q != CNT_MAX) begin
                        // Saturating: the counter never wraps back to a
                        // small value that could re-trigger a compare.
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Output decode on the next state, registered so R is glitch-free.
    always_comb begin
        r_d = 1'b0;
        if (state_d == DONE) begin
            r_d = 1'b1;
        end
    end

    assign R = r_q;

endmodule

// File: tb/tb_timer.sv
module tb_timer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       F;
    logic [3:0] middle_p;
    logic       r_q1;
    logic       r_q2;

    always #5 clk = ~clk;

    timer #(.QUARTER(1), .CNT_W(4)) u_q1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .middle_p (middle_p),
        .F        (F),
        .R        (r_q1)
    );

    timer #(.QUARTER(2), .CNT_W(4)) u_q2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .middle_p (middle_p),
        .F        (F),
        .R        (r_q2)
    );

    int vectors     = 0;
    int miscompares = 0;
    int edge_n      = 0;

    // Reference model: per instance, whether an addition is being timed and
    // the edge number after which R must be high.
    int quarter_of[2] = '{1, 2};
    bit armed[2];
    int ready_at[2];

    // Expected R of both instances after each edge, bit0 = QUARTER 1.
    logic [1:0] exp_q[$];
    logic [1:0] mon_e;

    function automatic int run_class(input logic [3:0] p);
        int best = 0;
        int cur  = 0;
        for (int i = 0; i < 4; i++) begin
            if (p[i]) cur++;
            else cur = 0;
            if (cur > best) best = cur;
        end
        if (best >= 4) return 4;
        if (best == 3) return 3;
        if (best == 2) return 2;
        return 1;
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: R=%b expected %b (edge %0d, t=%0t)", name, act, exp, edge_n, $time);
        end
    endtask

    // Monitor: compares each settled output against the queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("R_quarter1", r_q1, mon_e[0]);
            check("R_quarter2", r_q2, mon_e[1]);
        end
    end

    // Drive one cycle of inputs, let the edge happen, queue the expectation.
    task automatic step(input logic f, input logic [3:0] mp);
        logic [1:0] e;
        F        = f;
        middle_p = mp;
        @(posedge clk);
        edge_n++;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                armed[k] = 1'b0;
            end else if (f) begin
                armed[k]    = 1'b1;
                ready_at[k] = edge_n + run_class(mp) * quarter_of[k];
            end
            e[k] = armed[k] && (edge_n >= ready_at[k]);
        end
        exp_q.push_back(e);
        #1;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'($urandom_range(0, 15)));
    endtask

    // Assert reset between edges; R must fall without a clock.
    task automatic async_reset(input string name);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        armed[0] = 1'b0;
        armed[1] = 1'b0;
        #1;
        check({name, "_q1"}, r_q1, 1'b0);
        check({name, "_q2"}, r_q2, 1'b0);
    endtask

    initial begin
        rst_n    = 1'b0;
        F        = 1'b0;
        middle_p = 4'b0000;
        armed    = '{1'b0, 1'b0};
        ready_at = '{0, 0};
        #2;
        check("reset_q1", r_q1, 1'b0);
        check("reset_q2", r_q2, 1'b0);

        // F toggling during reset must not raise R.
        for (int i = 0; i < 6; i++) step(1'(i % 2 == 0), 4'b1111);
        rst_n = 1'b1;
        idle_steps(10);

        // Graded chains: class 1..4 on both quarters, then hold.
        step(1'b1, 4'b0101); idle_steps(10);
        step(1'b1, 4'b0011); idle_steps(10);
        step(1'b1, 4'b1110); idle_steps(10);
        step(1'b1, 4'b1111); idle_steps(10);
        step(1'b1, 4'b1001); idle_steps(10);
        step(1'b1, 4'b0111); idle_steps(10);

        // Latch check: operand change after the F edge is ignored.
        step(1'b1, 4'b1111);
        for (int i = 0; i < 10; i++) step(1'b0, 4'b0000);

        // Held F for three cycles.
        for (int i = 0; i < 3; i++) step(1'b1, 4'b0001);
        idle_steps(6);

        // Restart from DONE.
        step(1'b1, 4'b0110); idle_steps(6);

        // Restart mid-count of a class-4 run.
        step(1'b1, 4'b1111); idle_steps(2);
        step(1'b1, 4'b0011); idle_steps(8);

        // Async reset during COUNT, F toggling while held, no R after release.
        step(1'b1, 4'b1111); idle_steps(1);
        async_reset("async_count");
        step(1'b1, 4'b1111); step(1'b0, 4'b1111); step(1'b1, 4'b0001);
        rst_n = 1'b1;
        idle_steps(10);

        // Async reset in DONE.
        step(1'b1, 4'b0001); idle_steps(10);
        async_reset("async_done");
        rst_n = 1'b1;
        idle_steps(8);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                async_reset("async_random");
                step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
                rst_n = 1'b1;
            end
            step(1'($urandom_range(0, 5) == 0), 4'($urandom_range(0, 15)));
        end
        idle_steps(10);

        @(negedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
